// File: rtl/find_max_frame.sv
// -----------------------------------------------------------------------------
// find_max_frame
//
// Purpose:
//   Takes a stream of DATA_W-bit words and sends each one, one at a time,
//   through an external transform unit (add_one or similar). It keeps the
//   maximum of the transformed values over a frame of FRAME_LEN words and
//   returns that maximum once per frame. The optional index output
//   (FIND_MAX_INDEX_EN) reports where in the frame the maximum appeared.
//
// Handshake (every channel): a transfer completes on a rising clk edge where
//   vld=1 and busy=0. A producer holds vld and data stable until then. Each
//   busy/vld this block drives is a register, so it only changes on an edge.
//
// Parameters:
//   DATA_W    : width of every data bus
//   FRAME_LEN : words per frame, 1..65536
//   SIGNED    : 1 compares as two's complement, 0 compares as unsigned
//
// Build option:
//   FIND_MAX_INDEX_EN : when defined, adds the find_max_return_idx port and
//                       the index registers behind it
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   find_max_x_*             input word channel (vld/data in, busy out)
//   add_one_x_out_*          word offered to the transform (vld/data out, busy in)
//   add_one_return_in_*      transform result (vld/data in, busy out)
//   find_max_return_*        frame maximum (vld/data out, busy in)
//   find_max_return_idx      index of the maximum within its frame (option)
// -----------------------------------------------------------------------------
module find_max_frame #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned SIGNED    = 0,
   localparam int unsigned IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   // input word channel
   input  logic              find_max_x_vld,
   input  logic [DATA_W-1:0] find_max_x_data,
   output logic              find_max_x_busy,
   // word out to the transform unit
   output logic              add_one_x_out_vld,
   output logic [DATA_W-1:0] add_one_x_out_data,
   input  logic              add_one_x_out_busy,
   // result back from the transform unit
   input  logic              add_one_return_in_vld,
   input  logic [DATA_W-1:0] add_one_return_in_data,
   output logic              add_one_return_in_busy,
   // frame maximum out
   output logic              find_max_return_vld,
   output logic [DATA_W-1:0] find_max_return_data,
   input  logic              find_max_return_busy
`ifdef FIND_MAX_INDEX_EN
   ,
   output logic [IDX_W-1:0]  find_max_return_idx
`endif
);

   typedef enum logic [1:0] {
      RECV = 2'd0,   // waiting for an input word
      CALL = 2'd1,   // offering the captured word to the transform
      WAIT = 2'd2,   // waiting for the transform result
      SEND = 2'd3    // offering the frame maximum
   } state_t;

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   max_q, max_d;

   // Output registers
   logic                x_busy_q, x_busy_d;
   logic                out_vld_q, out_vld_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                ret_busy_q, ret_busy_d;
   logic                rvld_q, rvld_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef FIND_MAX_INDEX_EN
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    ridx_q, ridx_d;
   logic [IDX_W-1:0]    idx_upd;
`endif

   // Transfers are qualified with the registered busy/vld this block drives,
   // so the reset cycle (state RECV but x_busy still 1) accepts nothing.
   logic x_xfer, out_xfer, ret_xfer, rsp_xfer;
   assign x_xfer   = find_max_x_vld        & ~x_busy_q;
   assign out_xfer = out_vld_q             & ~add_one_x_out_busy;
   assign ret_xfer = add_one_return_in_vld & ~ret_busy_q;
   assign rsp_xfer = rvld_q                & ~find_max_return_busy;

   // Strict greater-than in the configured number format.
   logic res_gt;
   always_comb begin
      if (SIGNED != 0) begin
         res_gt = $signed(add_one_return_in_data) > $signed(max_q);
      end else begin
         res_gt = add_one_return_in_data > max_q;
      end
   end

   // The first element of a frame always loads; after that only a strictly
   // larger value replaces the maximum, so ties keep the earliest element.
   logic              take_new;
   logic [DATA_W-1:0] max_upd;
   assign take_new = (cnt_q == '0) | res_gt;
   assign max_upd  = take_new ? add_one_return_in_data : max_q;

`ifdef FIND_MAX_INDEX_EN
   assign idx_upd  = take_new ? cnt_q : idx_q;
`endif

   // Next-state and output-register logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      max_d      = max_q;
      out_data_d = out_data_q;
      rdata_d    = rdata_q;
`ifdef FIND_MAX_INDEX_EN
      idx_d      = idx_q;
      ridx_d     = ridx_q;
`endif

      case (state_q)
         RECV: begin
            if (x_xfer) begin
               out_data_d = find_max_x_data;
               state_d    = CALL;
            end
         end

         CALL: begin
            if (out_xfer) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (ret_xfer) begin
               max_d = max_upd;
`ifdef FIND_MAX_INDEX_EN
               idx_d = idx_upd;
`endif
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  rdata_d = max_upd;
`ifdef FIND_MAX_INDEX_EN
                  ridx_d  = idx_upd;
`endif
                  state_d = SEND;
               end else begin
                  cnt_d   = cnt_q + IDX_W'(1);
                  state_d = RECV;
               end
            end
         end

         SEND: begin
            if (rsp_xfer) begin
               state_d = RECV;
            end
         end

         default: begin
            state_d = RECV;
         end
      endcase

      // Handshake outputs are decoded from the next state and registered,
      // so each one changes on the same edge as the state it belongs to.
      x_busy_d   = (state_d != RECV);
      out_vld_d  = (state_d == CALL);
      ret_busy_d = (state_d != WAIT);
      rvld_d     = (state_d == SEND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RECV;
         cnt_q      <= '0;
         max_q      <= '0;
         x_busy_q   <= 1'b1;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         ret_busy_q <= 1'b1;
         rvld_q     <= 1'b0;
         rdata_q    <= '0;
`ifdef FIND_MAX_INDEX_EN
         idx_q      <= '0;
         ridx_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         max_q      <= max_d;
         x_busy_q   <= x_busy_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         ret_busy_q <= ret_busy_d;
         rvld_q     <= rvld_d;
         rdata_q    <= rdata_d;
`ifdef FIND_MAX_INDEX_EN
         idx_q      <= idx_d;
         ridx_q     <= ridx_d;
`endif
      end
   end

   assign find_max_x_busy        = x_busy_q;
   assign add_one_x_out_vld      = out_vld_q;
   assign add_one_x_out_data     = out_data_q;
   assign add_one_return_in_busy = ret_busy_q;
   assign find_max_return_vld    = rvld_q;
   assign find_max_return_data   = rdata_q;
`ifdef FIND_MAX_INDEX_EN
   assign find_max_return_idx    = ridx_q;
`endif

endmodule
